// File: rtl/complex_arithmetic_module.sv
// Four-stage pipelined Y = A*B + C*D*E + F in full-precision signed arithmetic.
// Every stage advances only on ce; rst_n clears the whole pipeline asynchronously.
module complex_arithmetic_module (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic [17:0] A,
  input  logic [7:0]  B,
  input  logic [11:0] C,
  input  logic [7:0]  D,
  input  logic [13:0] E,
  input  logic [18:0] F,
  output logic [35:0] Y
);

  // Stage 1: registered operands
  logic signed [17:0] a_q;
  logic signed [7:0]  b_q;
  logic signed [11:0] c_q;
  logic signed [7:0]  d_q;
  logic signed [13:0] e1_q;
  logic signed [18:0] f1_q;

  // Stage 2: first products, E and F carried along
  logic signed [25:0] p1_d, p1_q;
  logic signed [19:0] p2_d, p2_q;
  logic signed [13:0] e2_q;
  logic signed [18:0] f2_q;

  // Stage 3: triple product, P1 and F carried along
  logic signed [33:0] p3_d, p3_q;
  logic signed [25:0] p1_3_q;
  logic signed [18:0] f3_q;

  // Stage 4: final sum
  logic signed [35:0] y_d, y_q;

  // Operands are sign-extended to the product width so nothing is truncated.
  always_comb begin
    p1_d = 26'(a_q) * 26'(b_q);
    p2_d = 20'(c_q) * 20'(d_q);
    p3_d = 34'(p2_q) * 34'(e2_q);
    y_d  = 36'(p1_3_q) + 36'(p3_q) + 36'(f3_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      e1_q   <= '0;
      f1_q   <= '0;
      p1_q   <= '0;
      p2_q   <= '0;
      e2_q   <= '0;
      f2_q   <= '0;
      p3_q   <= '0;
      p1_3_q <= '0;
      f3_q   <= '0;
      y_q    <= '0;
    end else if (ce) begin
      a_q    <= A;
      b_q    <= B;
      c_q    <= C;
      d_q    <= D;
      e1_q   <= E;
      f1_q   <= F;
      p1_q   <= p1_d;
      p2_q   <= p2_d;
      e2_q   <= e1_q;
      f2_q   <= f1_q;
      p3_q   <= p3_d;
      p1_3_q <= p1_q;
      f3_q   <= f2_q;
      y_q    <= y_d;
    end
  end

  assign Y = y_q;

endmodule

// File: tb/tb_complex_arithmetic_module.sv
// Directed bench for complex_arithmetic_module: reset, nominal, unity, extremes,
// stall, asynchronous reset and a 20-set streaming run against a longint model.
module tb_complex_arithmetic_module;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic [17:0] A;
  logic [7:0]  B;
  logic [11:0] C;
  logic [7:0]  D;
  logic [13:0] E;
  logic [18:0] F;
  logic [35:0] Y;

  int checks   = 0;
  int failures = 0;

  localparam logic [35:0] Y_NOM  = 36'(71129362);
  localparam logic [35:0] Y_EXT  = 36'(-64'sd2130968576);
  localparam logic [35:0] Y_X    = 36'(133);
  localparam logic [35:0] Y_UNIT = 36'(3);

  complex_arithmetic_module dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ce   (ce),
    .A    (A),
    .B    (B),
    .C    (C),
    .D    (D),
    .E    (E),
    .F    (F),
    .Y    (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_ops(input int a, input int b, input int c, input int d,
                         input int e, input int f);
    A = 18'(a);
    B = 8'(b);
    C = 12'(c);
    D = 8'(d);
    E = 14'(e);
    F = 19'(f);
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
    $display("check %-14s Y=%0d expected=%0d", tag, $signed(obs), $signed(exp));
  endtask

  function automatic logic [35:0] model(input logic signed [17:0] a, input logic signed [7:0] b,
                                        input logic signed [11:0] c, input logic signed [7:0] d,
                                        input logic signed [13:0] e, input logic signed [18:0] f);
    longint r;
    r = longint'(a) * longint'(b) + longint'(c) * longint'(d) * longint'(e) + longint'(f);
    return 36'(r);
  endfunction

  logic [35:0] exp_s [0:19];

  initial begin
    rst_n = 1'b1;
    ce    = 1'b0;
    set_ops(0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1 check("reset_async", Y, 36'(0));

    // Reset dominates ce even with nonzero operands.
    ce = 1'b1;
    set_ops(-25687, 59, -630, 36, -3200, 68895);
    for (int i = 0; i < 5; i++) step();
    check("reset_over_ce", Y, 36'(0));

    // Release with nominal operands held: zero for 3 edges, result on the 4th.
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("fill_zero_%0d", i), Y, 36'(0));
    end
    step();
    check("nominal", Y, Y_NOM);
    step();
    step();
    check("nominal_hold", Y, Y_NOM);

    // Unity then E=-1.
    set_ops(1, 1, 1, 1, 1, 1);
    for (int i = 0; i < 3; i++) step();
    check("unity_lat3", Y, Y_NOM);
    step();
    check("unity", Y, Y_UNIT);
    set_ops(1, 1, 1, 1, -1, 1);
    for (int i = 0; i < 3; i++) step();
    check("unity_e_lat3", Y, Y_UNIT);
    step();
    check("unity_e_neg", Y, 36'(1));

    // Most negative operands: triple product reaches -2^31 without wrapping.
    set_ops(-131072, -128, -2048, -128, -8192, -262144);
    for (int i = 0; i < 4; i++) step();
    check("extremes", Y, Y_EXT);

    // Stall: nominal then a second set X enter, then ce low for 5 cycles while
    // inputs show a set that must never be sampled, then resume with unity.
    set_ops(-25687, 59, -630, 36, -3200, 68895);
    step();
    set_ops(2, 3, 4, 5, 6, 7);
    step();
    ce = 1'b0;
    set_ops(9, 9, 9, 9, 9, 9);
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("stall_hold_%0d", i), Y, Y_EXT);
    end
    set_ops(1, 1, 1, 1, 1, 1);
    ce = 1'b1;
    step();
    check("stall_edge3", Y, Y_EXT);
    step();
    check("stall_nominal", Y, Y_NOM);
    step();
    check("stall_next_x", Y, Y_X);
    step();
    check("stall_unity", Y, Y_UNIT);

    // Async reset mid-operation with nominal data in flight.
    set_ops(-25687, 59, -630, 36, -3200, 68895);
    step();
    step();
    #3 rst_n = 1'b0;
    #1 check("async_reset", Y, 36'(0));
    set_ops(1, 1, 1, 1, 1, 1);
    step();
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("refill_zero_%0d", i), Y, 36'(0));
    end
    step();
    check("refill_unity", Y, Y_UNIT);

    // Streaming: a fresh operand set every edge, result 4 edges later.
    for (int i = 0; i < 23; i++) begin
      if (i < 20) begin
        A = 18'($urandom);
        B = 8'($urandom);
        C = 12'($urandom);
        D = 8'($urandom);
        E = 14'($urandom);
        F = 19'($urandom);
        exp_s[i] = model(A, B, C, D, E, F);
      end
      step();
      if (i >= 3) check($sformatf("stream_%0d", i - 3), Y, exp_s[i - 3]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/complex_arithmetic_module.md
COMPLEX_ARITHMETIC_MODULE -- requirements
Module: complex_arithmetic_module

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  single clock; all registers update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ce  input  1  clock enable for every pipeline register.
REQ-005 A  input  18  signed two's-complement operand.
REQ-006 B  input  8  signed operand.
REQ-007 C  input  12  signed operand.
REQ-008 D  input  8  signed operand.
REQ-009 E  input  14  signed operand.
REQ-010 F  input  19  signed operand.
REQ-011 Y  output  36  signed result, registered.

Function
REQ-012 Y SHALL equal A*B + C*D*E + F, computed in full-precision signed arithmetic.
REQ-013 The result SHALL have no truncation, rounding or saturation.
REQ-014 Intermediate widths SHALL be at least the following:
- A*B: 26 bits
- C*D: 20 bits
- C*D*E: 34 bits
- each sum: 36 bits, with sign extension.
REQ-015 The worst case SHALL fit 36 bits without overflow, with |C*D*E| <= 2^31 and |A*B| <= 2^24.
REQ-016 Pipeline stage 1 SHALL register A, B, C, D, E and F.
REQ-017 Stage 2 SHALL register P1 = A*B and P2 = C*D, and SHALL carry E and F forward.
REQ-018 Stage 3 SHALL register P3 = P2*E, and SHALL carry P1 and F forward.
REQ-019 Stage 4 SHALL register Y = P1 + P3 + F.
REQ-020 Latency SHALL be 4 ce-qualified rising edges from input sampling to Y.
REQ-021 Throughput SHALL be one new operand set per ce-qualified edge.
REQ-022 When ce = 0, all pipeline registers, including Y, SHALL hold their values.
REQ-023 A stall SHALL neither lose nor duplicate data in flight.
REQ-024 Operand sets SHALL be independent; there is no accumulation across cycles.
REQ-025 Inputs SHALL be sampled only on ce-qualified edges; input changes between edges have no effect.
REQ-026 No handshake exists; a valid result is implied by the fixed latency.

Reset
REQ-027 While rst_n = 0, every pipeline register SHALL clear to 0 immediately, without waiting for clk, and Y SHALL read 0.
REQ-028 Reset SHALL take priority over ce.
REQ-029 Reset mid-operation SHALL discard all in-flight data.
REQ-030 After rst_n rises with constant inputs and ce = 1, Y SHALL be 0 for edges 1-3 and correct from edge 4 onward.
REQ-031 In-flight zeros during that fill SHALL produce Y = 0, because the 0*0 + 0*0*0 + 0 terms are all 0.

Verification
REQ-032 Nominal: A=-25687 (18'b111001101110101001), B=59, C=-630, D=36, E=-3200, F=68895, ce=1 -> Y = 71129362 after 4 edges, stable thereafter.
REQ-033 Unity: A=B=C=D=E=F=1 -> Y = 3; then E=-1 -> Y = 1 four edges later.
REQ-034 Extremes: A=-131072, B=-128, C=-2048, D=-128, E=-8192, F=-262144 -> Y = -2130968576, with no wrap.
REQ-035 Stall: apply new operands, then deassert ce for 5 cycles mid-pipeline -> Y frozen; the correct result appears after 4 total ce-qualified edges.
REQ-036 Reset: assert rst_n = 0 asynchronously between clock edges while Y is nonzero -> Y = 0 immediately; after release, REQ-030 behaviour holds.
REQ-037 Streaming: apply a different operand set every cycle for 20 cycles -> each Y matches the reference model for the set sampled 4 edges earlier.
